serial_add_ctrl: RTL and testbench

Bit-serial add/subtract controller that time-shares one `full_adder` cell across a WIDTH-bit operation. It accepts an operand pair over a valid/ready handshake and feeds the cell one bit per clock, LSB first, with a registered carry. It returns the result, carry-out and signed-overflow over a second valid/ready handshake. It is the sequencer for the existing single-bit adder datapath and trades latency for area.

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/full_adder.sv | 16 +
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_serial_add_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
package serial_add_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, time-shared by the serial sequencer.
module full_adder (
    input  logic cin,
    input  logic a,
    input  logic b,
    output logic cout,
    output logic sum
);

    logic prop;

    assign prop = a ^ b;
    assign sum  = prop ^ cin;
    assign cout = (a & b) | (cin & prop);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full_adder cell, LSB first, registered carry.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             msb_cin_q, msb_cin_d;

    logic fa_sum;
    logic fa_cout;

    full_adder u_full_adder (
        .cin  (carry_q),
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cout (fa_cout),
        .sum  (fa_sum)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = op_a;
                    // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    msb_cin_d = carry_q;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && rst_n;
    assign out_valid = (state_q == StDone);
    assign result    = res_q;
    assign cout      = carry_q;
    assign overflow  = msb_cin_q ^ carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int checks = 0;
    int failures = 0;
    int lat;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, then count clocks until out_valid (bounded).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int cycles);
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        sub      = ~s;
        cycles   = 1;
        while (!out_valid && cycles < 40) begin
            step();
            if (!out_valid) cycles++;
        end
        if (!out_valid) cycles = -1;
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] r, input logic c,
                                 input logic v);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(r));
        check({tag, "_cout"}, 32'(cout), 32'(c));
        check({tag, "_ovf"}, 32'(overflow), 32'(v));
    endtask

    initial begin
        // Reset
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // 0x5A + 0x3C with out_ready held high
        out_ready = 1'b1;
        op_a = 8'h5A; op_b = 8'h3C; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("run_in_ready", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            if (!out_valid) lat++;
        end
        check("add1_latency", 32'(lat), 32'd8);
        expect_result("add1", 8'h96, 1'b0, 1'b1);
        step();
        check("add1_hs_in_ready", 32'(in_ready), 32'd1);
        check("add1_hs_out_valid", 32'(out_valid), 32'd0);

        // 0xFF + 0x01
        issue(8'hFF, 8'h01, 1'b0, lat);
        check("add2_latency", 32'(lat), 32'd8);
        expect_result("add2", 8'h00, 1'b1, 1'b0);
        step();
        check("add2_hs_in_ready", 32'(in_ready), 32'd1);

        // 0x10 - 0x20
        issue(8'h10, 8'h20, 1'b1, lat);
        expect_result("sub1", 8'hF0, 1'b0, 1'b0);
        step();

        // 0x80 - 0x01
        issue(8'h80, 8'h01, 1'b1, lat);
        expect_result("sub2", 8'h7F, 1'b1, 1'b1);
        step();

        // Backpressure with in_valid pulsed during DONE
        out_ready = 1'b0;
        issue(8'h33, 8'h44, 1'b0, lat);
        check("bp_latency", 32'(lat), 32'd8);
        op_a = 8'hAA; op_b = 8'h11; sub = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            step();
            expect_result($sformatf("bp%0d", i), 8'h77, 1'b0, 1'b0);
            check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_hs_in_ready", 32'(in_ready), 32'd1);
        check("bp_hs_out_valid", 32'(out_valid), 32'd0);
        check("bp_hs_result", 32'(result), 32'h77);
        step();
        check("bp_no_accept", 32'(in_ready), 32'd1);

        // Reset during RUN cycle 3
        op_a = 8'h5A; op_b = 8'h3C; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_rel_in_ready", 32'(in_ready), 32'd1);
        issue(8'h01, 8'h01, 1'b0, lat);
        check("post_latency", 32'(lat), 32'd8);
        expect_result("post", 8'h02, 1'b0, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
